// File: rtl/fpu_op_driver_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module      : fpu_op_driver_if                                     |
// | Description : Command/result handshakes and FPU operand/result     |
// |               handshakes around the FPU operation driver.          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface fpu_op_driver_if;
  // command side
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_valid;
  logic        cmd_ready;
  // result side
  logic [31:0] res_z;
  logic        res_valid;
  logic        res_ready;
  logic        res_timeout;
  // FPU operand A
  logic [31:0] fpu_a;
  logic        fpu_a_req;
  logic        fpu_a_ack;
  // FPU operand B
  logic [31:0] fpu_b;
  logic        fpu_b_req;
  logic        fpu_b_ack;
  // FPU result
  logic [31:0] fpu_z;
  logic        fpu_z_req;
  logic        fpu_z_ack;

  // The driver itself: it masters the FPU transaction sequence.
  modport master (
    input  cmd_a, cmd_b, cmd_valid, res_ready,
    input  fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_req,
    output cmd_ready, res_z, res_valid, res_timeout,
    output fpu_a, fpu_a_req, fpu_b, fpu_b_req, fpu_z_ack
  );

  // The surroundings: command source, result sink and the FPU.
  modport slave (
    output cmd_a, cmd_b, cmd_valid, res_ready,
    output fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_req,
    input  cmd_ready, res_z, res_valid, res_timeout,
    input  fpu_a, fpu_a_req, fpu_b, fpu_b_req, fpu_z_ack
  );
endinterface
`default_nettype wire

// File: rtl/fpu_op_driver.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module      : fpu_op_driver                                        |
// | Description : Sequences one FPU operation per command: sends A,    |
// |               sends B, collects Z, returns the result. Any stalled |
// |               handshake aborts with a quiet-NaN timeout result.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module fpu_op_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  fpu_op_driver_if.master        bus,
  output logic [15:0]            ops_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_B = 3'd2;
  localparam logic [2:0] S_WAIT_Z = 3'd3;
  localparam logic [2:0] S_ACK_Z  = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;

  logic [2:0]  state_q,       state_d;
  logic        cmd_ready_q,   cmd_ready_d;
  logic        res_valid_q,   res_valid_d;
  logic        res_timeout_q, res_timeout_d;
  logic [31:0] res_z_q,       res_z_d;
  logic [31:0] fpu_a_q,       fpu_a_d;
  logic [31:0] fpu_b_q,       fpu_b_d;
  logic [31:0] b_hold_q,      b_hold_d;
  logic        fpu_a_req_q,   fpu_a_req_d;
  logic        fpu_b_req_q,   fpu_b_req_d;
  logic        fpu_z_ack_q,   fpu_z_ack_d;
  logic [15:0] ops_done_q,    ops_done_d;
  logic [15:0] stall_q,       stall_d;

  logic a_xfer;
  logic b_xfer;
  logic stall_hit;
  logic stall_state;
  logic timeout;

  // Handshakes only count when our own req is up, so stray acks are ignored.
  assign a_xfer      = fpu_a_req_q & bus.fpu_a_ack;
  assign b_xfer      = fpu_b_req_q & bus.fpu_b_ack;
  assign stall_hit   = (stall_q == STALL_LIMIT);
  assign stall_state = (state_q == S_SEND_A) || (state_q == S_SEND_B) ||
                       (state_q == S_WAIT_Z) || (state_q == S_ACK_Z);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a real transition always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) state_d = S_SEND_A;
      end
      S_SEND_A: begin
        if (a_xfer)         state_d = S_SEND_B;
        else if (stall_hit) timeout = 1'b1;
      end
      S_SEND_B: begin
        if (b_xfer)         state_d = S_WAIT_Z;
        else if (stall_hit) timeout = 1'b1;
      end
      S_WAIT_Z: begin
        if (bus.fpu_z_req)  state_d = S_ACK_Z;
        else if (stall_hit) timeout = 1'b1;
      end
      S_ACK_Z: begin
        if (!bus.fpu_z_req) state_d = S_RESULT;
        else if (stall_hit) timeout = 1'b1;
      end
      S_RESULT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_RESULT;
  end

  // Next values of every registered output, keyed on the current state.
  always_comb begin
    cmd_ready_d   = (state_d == S_IDLE);
    res_valid_d   = res_valid_q;
    res_timeout_d = res_timeout_q;
    res_z_d       = res_z_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    b_hold_d      = b_hold_q;
    fpu_a_req_d   = fpu_a_req_q;
    fpu_b_req_d   = fpu_b_req_q;
    fpu_z_ack_d   = fpu_z_ack_q;
    ops_done_d    = ops_done_q;
    // Restarts from zero on every state change, counts while parked.
    stall_d       = 16'd0;
    if (stall_state && (state_d == state_q)) stall_d = stall_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (state_d == S_SEND_A) begin
          fpu_a_d     = bus.cmd_a;
          b_hold_d    = bus.cmd_b;
          fpu_a_req_d = 1'b1;
        end
      end
      S_SEND_A: begin
        if (a_xfer) begin
          fpu_a_req_d = 1'b0;
          fpu_b_d     = b_hold_q;
          fpu_b_req_d = 1'b1;
        end
      end
      S_SEND_B: begin
        if (b_xfer) fpu_b_req_d = 1'b0;
      end
      S_WAIT_Z: begin
        if (bus.fpu_z_req) begin
          res_z_d     = bus.fpu_z;
          fpu_z_ack_d = 1'b1;
        end
      end
      S_ACK_Z: begin
        if (!bus.fpu_z_req) begin
          fpu_z_ack_d   = 1'b0;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b0;
          ops_done_d    = ops_done_q + 16'd1;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase

    // Abort: drop every handshake line and return a quiet NaN.
    if (timeout) begin
      fpu_a_req_d   = 1'b0;
      fpu_b_req_d   = 1'b0;
      fpu_z_ack_d   = 1'b0;
      res_z_d       = QNAN;
      res_timeout_d = 1'b1;
      res_valid_d   = 1'b1;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_z_q       <= 32'd0;
      fpu_a_q       <= 32'd0;
      fpu_b_q       <= 32'd0;
      b_hold_q      <= 32'd0;
      fpu_a_req_q   <= 1'b0;
      fpu_b_req_q   <= 1'b0;
      fpu_z_ack_q   <= 1'b0;
      ops_done_q    <= 16'd0;
      stall_q       <= 16'd0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      res_z_q       <= res_z_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      b_hold_q      <= b_hold_d;
      fpu_a_req_q   <= fpu_a_req_d;
      fpu_b_req_q   <= fpu_b_req_d;
      fpu_z_ack_q   <= fpu_z_ack_d;
      ops_done_q    <= ops_done_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.res_z       = res_z_q;
  assign bus.fpu_a       = fpu_a_q;
  assign bus.fpu_b       = fpu_b_q;
  assign bus.fpu_a_req   = fpu_a_req_q;
  assign bus.fpu_b_req   = fpu_b_req_q;
  assign bus.fpu_z_ack   = fpu_z_ack_q;
  assign ops_done        = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_driver.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module      : tb_fpu_op_driver                                     |
// | Description : Directed bench for fpu_op_driver with an FPU         |
// |               responder and a result scoreboard.                   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_fpu_op_driver;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ops_done;

  fpu_op_driver_if bus ();

  fpu_op_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event-missing expected event (cycle %0d)", name, cyc);
  endtask

  // The FPU's arithmetic for the operand pairs used here (hand-computed).
  function automatic logic [31:0] fpu_lookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000; //  2.0 * 3.0 =  6.0
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000; //  1.0 * 1.0 =  1.0
      {32'hC000_0000, 32'h3F00_0000}: return 32'hBF80_0000; // -2.0 * 0.5 = -1.0
      {32'h0000_0000, 32'h7F80_0000}: return 32'hFFC0_0000; //  0 * inf   =  NaN
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Knobs shared between the directed sequence and the responders.
  logic exp_to = 1'b0;   // next accepted command is expected to time out
  logic z_en   = 1'b1;   // FPU produces a result at all
  int   z_lat  = 2;      // cycles from B transfer to result
  int   z_drop = 0;      // extra cycles FPU holds fpu_z_req after seeing ack

  // FPU responder: captures operands, presents the product, drops req after ack.
  initial begin : fpu_model
    int          z_cnt;
    int          drop_cnt;
    logic [31:0] cap_a;
    logic [31:0] z_val;
    z_cnt         = -1;
    drop_cnt      = -1;
    cap_a         = 32'd0;
    z_val         = 32'd0;
    bus.fpu_z     = 32'd0;
    bus.fpu_z_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.fpu_z_req = 1'b0;
        z_cnt         = -1;
        drop_cnt      = -1;
      end else begin
        if (bus.fpu_z_req && bus.fpu_z_ack && drop_cnt < 0) drop_cnt = z_drop;
        if (drop_cnt == 0) begin
          bus.fpu_z_req = 1'b0;
          drop_cnt      = -1;
        end else if (drop_cnt > 0) begin
          drop_cnt--;
        end
        if (bus.fpu_a_req && bus.fpu_a_ack) cap_a = bus.fpu_a;
        if (z_cnt == 0) begin
          bus.fpu_z_req = 1'b1;
          bus.fpu_z     = z_val;
          z_cnt         = -1;
        end else if (z_cnt > 0) begin
          z_cnt--;
        end
        if (bus.fpu_b_req && bus.fpu_b_ack && z_en) begin
          z_val = fpu_lookup(cap_a, bus.fpu_b);
          z_cnt = z_lat;
        end
      end
    end
  end

  // Scoreboard state: one expected result per accepted command.
  typedef struct packed {
    logic [31:0] z;
    logic        to;
  } exp_t;

  exp_t        sbq[$];
  logic        busy     = 1'b0;
  logic        mon_en   = 1'b0;
  logic [15:0] exp_ops  = 16'd0;
  logic [31:0] last_z   = 32'd0;
  logic        last_to  = 1'b0;
  int          accepts  = 0;
  int          a_xfers  = 0;
  int          b_xfers  = 0;

  // Compare process: protocol rules every cycle, results on each consumption.
  initial begin : compare
    logic        p_rst, p_rv, p_rr, p_to, p_areq, p_aack, p_breq, p_back;
    logic [31:0] p_z, p_a, p_b;
    logic [1:0]  nreq;
    exp_t        e;
    p_rst = 1'b1; p_rv = 1'b0; p_rr = 1'b0; p_to = 1'b0;
    p_areq = 1'b0; p_aack = 1'b0; p_breq = 1'b0; p_back = 1'b0;
    p_z = 32'd0; p_a = 32'd0; p_b = 32'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        nreq = 2'(bus.fpu_a_req) + 2'(bus.fpu_b_req) + 2'(bus.fpu_z_ack);
        check("req_exclusive", 32'(nreq <= 2'd1), 32'd1);
        check("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
        if (!p_rst && p_rv && !p_rr) begin
          check("res_valid_hold",   32'(bus.res_valid),   32'd1);
          check("res_z_hold",       bus.res_z,            p_z);
          check("res_timeout_hold", 32'(bus.res_timeout), 32'(p_to));
        end
        if (!p_rst && p_areq && !p_aack && bus.fpu_a_req) check("fpu_a_hold", bus.fpu_a, p_a);
        if (!p_rst && p_breq && !p_back && bus.fpu_b_req) check("fpu_b_hold", bus.fpu_b, p_b);

        if (rst) begin
          busy    = 1'b0;
          exp_ops = 16'd0;
          sbq.delete();
        end else begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            busy = 1'b1;
            accepts++;
            e.to = exp_to;
            e.z  = exp_to ? QNAN : fpu_lookup(bus.cmd_a, bus.cmd_b);
            sbq.push_back(e);
          end
          if (bus.fpu_a_req && bus.fpu_a_ack) a_xfers++;
          if (bus.fpu_b_req && bus.fpu_b_ack) b_xfers++;
          if (bus.res_valid && bus.res_ready) begin
            busy = 1'b0;
            if (sbq.size() == 0) begin
              fail_now("unexpected_result");
            end else begin
              e = sbq.pop_front();
              if (!e.to) exp_ops = exp_ops + 16'd1;
              check("res_z",       bus.res_z,            e.z);
              check("res_timeout", 32'(bus.res_timeout), 32'(e.to));
              check("ops_done",    32'(ops_done),        32'(exp_ops));
            end
            last_z  = bus.res_z;
            last_to = bus.res_timeout;
          end
        end
      end
      p_rst = rst; p_rv = bus.res_valid; p_rr = bus.res_ready; p_to = bus.res_timeout;
      p_z = bus.res_z; p_a = bus.fpu_a; p_b = bus.fpu_b;
      p_areq = bus.fpu_a_req; p_aack = bus.fpu_a_ack;
      p_breq = bus.fpu_b_req; p_back = bus.fpu_b_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer a command until accepted; acc_cyc is the cycle count after the accept edge.
  task automatic issue_cmd(input logic [31:0] a, input logic [31:0] b, input logic to,
                           output int acc_cyc);
    int n;
    exp_to        = to;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    n             = 0;
    acc_cyc       = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 50);
    if (bus.cmd_ready) acc_cyc = cyc + 1;
    else               fail_now("cmd_accept_timeout");
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_consumed();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.res_valid && bus.res_ready) && n < 100);
    if (!(bus.res_valid && bus.res_ready)) fail_now("result_wait_timeout");
    tick();
  endtask

  task automatic wait_res_valid(output int rise_cyc);
    int n;
    n        = 0;
    rise_cyc = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 100);
    if (bus.res_valid) rise_cyc = cyc;
    else               fail_now("res_valid_wait_timeout");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got still-running expected finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc, rise, a0, b0, acc0, n;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    bus.fpu_a_ack = 1'b1;
    bus.fpu_b_ack = 1'b1;

    // Reset values
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    check("rst_res_valid",   32'(bus.res_valid),   32'd0);
    check("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
    check("rst_res_z",       bus.res_z,            32'd0);
    check("rst_fpu_a",       bus.fpu_a,            32'd0);
    check("rst_fpu_b",       bus.fpu_b,            32'd0);
    check("rst_reqs",        32'({bus.fpu_a_req, bus.fpu_b_req, bus.fpu_z_ack}), 32'd0);
    check("rst_ops_done",    32'(ops_done),        32'd0);
    tick();

    // Nominal 2.0 * 3.0
    a0 = a_xfers; b0 = b_xfers;
    issue_cmd(32'h4000_0000, 32'h4040_0000, 1'b0, acc);
    wait_consumed();
    check("nom_res_z",   last_z,                 32'h40C0_0000);
    check("nom_timeout", 32'(last_to),           32'd0);
    check("nom_ops",     32'(ops_done),          32'd1);
    check("nom_a_xfers", 32'(a_xfers - a0),      32'd1);
    check("nom_b_xfers", 32'(b_xfers - b0),      32'd1);

    // Timeout in SEND_A
    bus.fpu_a_ack = 1'b0;
    issue_cmd(32'h4000_0000, 32'h4040_0000, 1'b1, acc);
    wait_res_valid(rise);
    check("to_latency",   32'(rise - acc),         32'd16);
    check("to_res_z",     bus.res_z,               QNAN);
    check("to_flag",      32'(bus.res_timeout),    32'd1);
    check("to_a_req",     32'(bus.fpu_a_req),      32'd0);
    check("to_ops",       32'(ops_done),           32'd1);
    tick();
    bus.fpu_a_ack = 1'b1;
    tick();

    // Result backpressure with a competing command
    bus.res_ready = 1'b0;
    acc0 = accepts;
    issue_cmd(32'h3F80_0000, 32'h3F80_0000, 1'b0, acc);
    wait_res_valid(rise);
    check("bp_res_z", bus.res_z, 32'h3F80_0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.cmd_a     = 32'hC000_0000;
      bus.cmd_b     = 32'h3F00_0000;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_res_z_hold", bus.res_z, 32'h3F80_0000);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_consumed();
    check("bp_accepts", 32'(accepts - acc0), 32'd1);
    check("bp_ops",     32'(ops_done),       32'd2);

    // Reset while in SEND_B
    bus.fpu_b_ack = 1'b0;
    issue_cmd(32'h4000_0000, 32'h4040_0000, 1'b0, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.fpu_b_req && n < 20);
    if (!bus.fpu_b_req) fail_now("send_b_reach");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rmid_b_req",     32'(bus.fpu_b_req), 32'd0);
    check("rmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rmid_res_valid", 32'(bus.res_valid), 32'd0);
    check("rmid_ops",       32'(ops_done),      32'd0);
    bus.fpu_b_ack = 1'b1;
    tick();
    issue_cmd(32'h4000_0000, 32'h4040_0000, 1'b0, acc);
    wait_consumed();
    check("rmid_after_z",   last_z,        32'h40C0_0000);
    check("rmid_after_ops", 32'(ops_done), 32'd1);

    // Back-to-back, one with a lingering fpu_z_req
    do_reset();
    issue_cmd(32'h3F80_0000, 32'h3F80_0000, 1'b0, acc);
    wait_consumed();
    check("b2b_1", last_z, 32'h3F80_0000);
    z_drop = 3;
    z_lat  = 0;
    issue_cmd(32'hC000_0000, 32'h3F00_0000, 1'b0, acc);
    wait_consumed();
    check("b2b_2", last_z, 32'hBF80_0000);
    z_drop = 0;
    z_lat  = 2;
    issue_cmd(32'h0000_0000, 32'h7F80_0000, 1'b0, acc);
    wait_consumed();
    check("b2b_3",   last_z,        32'hFFC0_0000);
    check("b2b_ops", 32'(ops_done), 32'd3);

    // Timeout while waiting for Z
    z_en = 1'b0;
    issue_cmd(32'h4000_0000, 32'h4040_0000, 1'b1, acc);
    wait_consumed();
    check("wz_to_flag", 32'(last_to),    32'd1);
    check("wz_to_z",    last_z,          QNAN);
    check("wz_to_ops",  32'(ops_done),   32'd3);
    z_en = 1'b1;

    // ops_done wrap
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFF;
    exp_ops = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done_q;
    tick();
    issue_cmd(32'h4000_0000, 32'h4040_0000, 1'b0, acc);
    wait_consumed();
    check("wrap_ops", 32'(ops_done), 32'd0);
    check("wrap_z",   last_z,        32'h40C0_0000);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_op_driver.md
FPU_OP_DRIVER -- requirements
Module: fpu_op_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: handshake-stall limit in clock cycles, range 2..65535.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port cmd_a, input, 32: IEEE-754 single-precision operand A.
REQ-005 SHALL have port cmd_b, input, 32: operand B.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted on any edge where cmd_valid=1 and cmd_ready=1.
REQ-008 SHALL have port res_z, output, 32: result word.
REQ-009 SHALL have port res_valid, output, 1: res_z and res_timeout are valid.
REQ-010 SHALL have port res_ready, input, 1: result consumed on any edge where res_valid=1 and res_ready=1.
REQ-011 SHALL have port res_timeout, output, 1: the result came from a timeout abort.
REQ-012 SHALL have port fpu_a, output, 32: operand A driven to the FPU.
REQ-013 SHALL have port fpu_a_req, output, 1: operand A request.
REQ-014 SHALL have port fpu_a_ack, input, 1: FPU ready for operand A.
REQ-015 SHALL have ports fpu_b (output, 32), fpu_b_req (output, 1) and fpu_b_ack (input, 1), with the same meanings for operand B.
REQ-016 SHALL have port fpu_z, input, 32: FPU result.
REQ-017 SHALL have port fpu_z_req, input, 1: FPU result valid.
REQ-018 SHALL have port fpu_z_ack, output, 1: result acknowledge to the FPU.
REQ-019 SHALL have port ops_done, output, 16: count of completed non-timeout operations, wraps 0xFFFF to 0x0000.

Function
REQ-020 SHALL register every output, with no combinational input-to-output paths.
REQ-021 SHALL implement states IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z and RESULT.
REQ-022 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 On IDLE with cmd_valid=1, SHALL latch cmd_a and cmd_b, set fpu_a to the latched A, set fpu_a_req=1 and enter SEND_A.
REQ-024 In SEND_A, an edge with fpu_a_req=1 and fpu_a_ack=1 SHALL be an A transfer: drive fpu_a_req=0, fpu_b to the latched B, fpu_b_req=1, and enter SEND_B.
REQ-025 In SEND_B, an edge with fpu_b_req=1 and fpu_b_ack=1 SHALL drive fpu_b_req=0 and enter WAIT_Z.
REQ-026 In WAIT_Z, on fpu_z_req=1, SHALL capture fpu_z into res_z, drive fpu_z_ack=1 and enter ACK_Z.
REQ-027 In ACK_Z, SHALL hold fpu_z_ack=1 until fpu_z_req=0 is sampled, then drive fpu_z_ack=0, res_valid=1, res_timeout=0, increment ops_done, and enter RESULT.
REQ-028 In RESULT, SHALL hold res_valid, res_z and res_timeout stable until res_ready=1, then clear res_valid and enter IDLE; no new command is accepted in that same cycle.
REQ-029 At most one of fpu_a_req, fpu_b_req and fpu_z_ack SHALL be 1 in any cycle.
REQ-030 fpu_a and fpu_b SHALL be stable while their respective req is 1.
REQ-031 SHALL keep a 16-bit stall counter, cleared on entry to SEND_A, SEND_B, WAIT_Z and ACK_Z, and incremented each cycle in those states.
REQ-032 When the stall counter reaches TIMEOUT_CYCLES-1 without a transition, SHALL drive fpu_a_req=0, fpu_b_req=0, fpu_z_ack=0, res_z=0x7FC00000, res_timeout=1, res_valid=1, and enter RESULT; ops_done SHALL be unchanged.
REQ-033 If a transition condition and the timeout occur on the same edge, the transition SHALL win.
REQ-034 Ack or req inputs that arrive in a state not waiting for them SHALL be ignored.
REQ-035 An edge where ACK_Z sees fpu_z_req=0 SHALL complete normally whether or not that req pulse was a single cycle.

Reset
REQ-036 With rst=1 at an edge, SHALL enter IDLE and set cmd_ready=1, res_valid=0, res_timeout=0, res_z=0, fpu_a=0, fpu_b=0, fpu_a_req=0, fpu_b_req=0, fpu_z_ack=0, ops_done=0, and stall counter=0.
REQ-037 rst SHALL override all other activity, including mid-handshake; an aborted operation SHALL produce no result.

Verification
REQ-038 Nominal: cmd_a=0x40000000, cmd_b=0x40400000, with the FPU model returning 0x40C00000 -> one A transfer, one B transfer, res_z=0x40C00000, res_timeout=0, ops_done=1.
REQ-039 Timeout: TIMEOUT_CYCLES=16 and fpu_a_ack held 0 -> res_valid rises 16 cycles after entering SEND_A, res_z=0x7FC00000, res_timeout=1, fpu_a_req=0, ops_done unchanged.
REQ-040 Backpressure: res_ready held 0 for 10 cycles after res_valid -> res_z stable throughout, cmd_ready=0, and a cmd_valid during that window is not accepted.
REQ-041 Reset mid-operation: rst pulsed while in SEND_B -> next cycle fpu_b_req=0, cmd_ready=1, res_valid=0; a following command completes normally.
REQ-042 Back-to-back: 3 commands (1.0*1.0, -2.0*0.5, 0*inf giving 0xFFC00000) with res_ready tied 1 -> results in order and ops_done=3.
REQ-043 Wrap: ops_done preloaded to 0xFFFF via 65535 operations, or by forcing it in the bench -> the next operation gives ops_done=0x0000.
